// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner: one-hot active-low row drive, synchronised column sense,
// whole-frame debounce, single/multi-key classification and a 1-deep press-event
// register with valid/ready handshake and sticky overflow.
module keypad_scanner #(
  parameter int unsigned ROWS     = 3,
  parameter int unsigned COLS     = 3,
  parameter int unsigned SCAN_DIV = 1200,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned KEY_W    = 4
) (
  input  logic             hwclk,
  input  logic             rst,
  output logic [ROWS-1:0]  row_n,
  input  logic [COLS-1:0]  col_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_down,
  output logic             key_multi,
  output logic             overflow
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  logic [COLS-1:0]  col_s1_q, col_s2_q;
  logic [RW-1:0]    r_q;
  logic [DW-1:0]    d_q;
  logic [N-1:0]     raw_q, raw_d, prev_q, deb_q;
  logic [CW-1:0]    stable_q, stable_d;
  logic             frame_end_q;
  logic             sample, frame_end, accept;
  logic             seen, multi, single, press_evt;
  logic [KEY_W-1:0] enc;
  logic [KEY_W-1:0] key_code_q;
  logic             key_valid_q, key_down_q, key_multi_q, overflow_q;

  assign sample    = (d_q == DW'(SCAN_DIV - 1));
  assign frame_end = sample && (r_q == RW'(ROWS - 1));

  // Two-flop column synchroniser; resets to the released (high) level.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      col_s1_q <= '1;
      col_s2_q <= '1;
    end else begin
      col_s1_q <= col_n;
      col_s2_q <= col_s1_q;
    end
  end

  // Row/dwell scan counters; the row advances on its last dwell cycle.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      r_q <= '0;
      d_q <= '0;
    end else if (sample) begin
      d_q <= '0;
      r_q <= (r_q == RW'(ROWS - 1)) ? '0 : r_q + RW'(1);
    end else begin
      d_q <= d_q + DW'(1);
    end
  end

  // Row drive follows the current row index directly.
  always_comb begin
    row_n = ~(ROWS'(1) << r_q);
  end

  // Raw frame with the current row's sample merged in, plus the debounce count update.
  always_comb begin
    raw_d    = raw_q;
    stable_d = stable_q;
    if (sample) begin
      raw_d[r_q*COLS +: COLS] = ~col_s2_q;
    end
    if (frame_end) begin
      if (raw_d != prev_q) begin
        stable_d = '0;
      end else if (stable_q != CW'(DEBOUNCE)) begin
        stable_d = stable_q + CW'(1);
      end
    end
  end

  // Accept only in the cycle right after frame end, while raw_q is a complete frame.
  assign accept = frame_end_q && (stable_q == CW'(DEBOUNCE)) && (raw_q != deb_q);

  // Frame registers and debounced matrix.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      raw_q       <= '0;
      prev_q      <= '0;
      deb_q       <= '0;
      stable_q    <= '0;
      frame_end_q <= 1'b0;
    end else begin
      raw_q       <= raw_d;
      stable_q    <= stable_d;
      frame_end_q <= frame_end;
      if (frame_end) prev_q <= raw_d;
      if (accept)    deb_q  <= raw_q;
    end
  end

  // Popcount classification (0 / 1 / >=2) and index of the set bit.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    enc   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (deb_q[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        enc  = KEY_W'(i);
      end
    end
  end

  assign single = seen && !multi;
  // Registered class lags deb_q by one cycle, so both low means the previous state was idle.
  assign press_evt = single && !key_down_q && !key_multi_q;

  // Level outputs and the 1-deep event register with handshake and sticky overflow.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      key_down_q  <= 1'b0;
      key_multi_q <= 1'b0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      key_down_q  <= single;
      key_multi_q <= multi;
      if (press_evt) begin
        if (key_valid_q && !key_ready) begin
          overflow_q <= 1'b1;
        end else begin
          key_code_q  <= enc;
          key_valid_q <= 1'b1;
        end
      end else if (key_valid_q && key_ready) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign key_multi = key_multi_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 3x3 keypad model driven from row_n.
module tb_keypad_scanner;

  logic       hwclk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] row_n;
  logic [2:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b1;
  logic       key_down;
  logic       key_multi;
  logic       overflow;

  logic [8:0] keys = '0;
  int         vectors = 0;
  int         errors = 0;
  int         ecount = 0;
  int         acc_cnt;
  logic [3:0] last_code;

  keypad_scanner #(
    .ROWS    (3),
    .COLS    (3),
    .SCAN_DIV(4),
    .DEBOUNCE(2),
    .KEY_W   (4)
  ) dut (
    .hwclk    (hwclk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_down (key_down),
    .key_multi(key_multi),
    .overflow (overflow)
  );

  always #5 hwclk = ~hwclk;

  // Keypad: a pressed key on a driven row pulls its column low.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (keys[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  // Accepted-event log.
  always @(posedge hwclk) begin
    if (rst) begin
      acc_cnt   <= 0;
      last_code <= '0;
    end else if (key_valid && key_ready) begin
      acc_cnt   <= acc_cnt + 1;
      last_code <= key_code;
    end
  end

  task automatic tick();
    @(posedge hwclk);
    #1;
    ecount++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Two reset cycles; ecount 0 is the last edge with rst high.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ecount = 0;
  endtask

  int first_v;
  int v_cycles;
  logic [3:0] code_at_v;
  logic down_at_v;

  initial begin
    // Reset state and first row advance.
    keys = '0;
    do_reset();
    check("rst_row_n", row_n, 3'b110);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_down", key_down, 0);
    check("rst_multi", key_multi, 0);
    check("rst_ovf", overflow, 0);
    run(3);
    check("row_hold_3", row_n, 3'b110);
    tick();
    check("row_step_4", row_n, 3'b101);

    // Clean press of row1/col2 from reset.
    do_reset();
    key_ready = 1'b1;
    keys = 9'b000100000;
    first_v = -1;
    v_cycles = 0;
    code_at_v = '0;
    down_at_v = 1'b0;
    for (int m = 0; m < 60; m++) begin
      if (key_valid) begin
        v_cycles++;
        if (first_v < 0) begin
          first_v = m;
          code_at_v = key_code;
          down_at_v = key_down;
        end
      end
      tick();
    end
    check("clean_edge", first_v, 38);
    check("clean_code", code_at_v, 5);
    check("clean_down", down_at_v, 1);
    check("clean_pulse", v_cycles, 1);
    keys = '0;
    run(60);
    check("clean_rel_down", key_down, 0);
    check("clean_events", acc_cnt, 1);

    // Bounce: press at edge 3, toggle every 5 cycles, hold from edge 43.
    do_reset();
    first_v = -1;
    v_cycles = 0;
    code_at_v = '0;
    for (int m = 0; m < 110; m++) begin
      if (m >= 43) keys[5] = 1'b1;
      else if (m >= 3) keys[5] = (((m - 3) / 5) % 2) == 0;
      else keys[5] = 1'b0;
      if (key_valid) begin
        v_cycles++;
        if (first_v < 0) begin
          first_v = m;
          code_at_v = key_code;
        end
      end
      tick();
    end
    check("bounce_edge", first_v, 86);
    check("bounce_code", code_at_v, 5);
    check("bounce_events", acc_cnt, 1);
    check("bounce_pulse", v_cycles, 1);
    keys = '0;

    // Ghost: codes 0 and 4 together, then drop 4, then full release and fresh press.
    do_reset();
    keys = 9'b000010001;
    run(60);
    check("ghost_multi", key_multi, 1);
    check("ghost_down", key_down, 0);
    check("ghost_ev0", acc_cnt, 0);
    keys = 9'b000000001;
    run(60);
    check("ghost_single_down", key_down, 1);
    check("ghost_single_multi", key_multi, 0);
    check("ghost_ev1", acc_cnt, 0);
    keys = '0;
    run(60);
    check("ghost_idle", key_down, 0);
    check("ghost_ev2", acc_cnt, 0);
    keys = 9'b000000001;
    run(60);
    check("ghost_fresh_ev", acc_cnt, 1);
    check("ghost_fresh_code", last_code, 0);
    keys = '0;

    // Handshake and overflow with the consumer stalled.
    do_reset();
    key_ready = 1'b0;
    keys = 9'b000000001;
    run(60);
    check("hs_valid0", key_valid, 1);
    check("hs_code0", key_code, 0);
    keys = '0;
    run(60);
    keys = 9'b100000000;
    run(60);
    check("hs_valid_hold", key_valid, 1);
    check("hs_code_kept", key_code, 0);
    check("hs_ovf", overflow, 1);
    check("hs_down8", key_down, 1);
    key_ready = 1'b1;
    tick();
    check("hs_drop", key_valid, 0);
    check("hs_acc_code", last_code, 0);
    run(60);
    check("hs_no8", key_valid, 0);
    check("hs_acc_cnt", acc_cnt, 1);
    check("hs_ovf_sticky", overflow, 1);

    // Reset with an event pending.
    keys = '0;
    key_ready = 1'b0;
    run(60);
    keys = 9'b000000010;
    run(60);
    check("mid_valid", key_valid, 1);
    check("mid_code", key_code, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_row", row_n, 3'b110);
    check("mid_rst_down", key_down, 0);
    keys = '0;
    key_ready = 1'b1;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner for the digital-lock front end. Drives ROWS row lines one-hot active-low, samples COLS active-low column inputs, debounces whole scan frames, rejects multi-key (ghost) states, and delivers one key code per press over a valid/ready handshake. Sits between the keypad pins and the code-entry/lock controller. It also exports a held-key level that drives the LEDs.

## Interface

- ROWS, 3, number of row lines (2..8)
- COLS, 3, number of column lines (2..8)
- SCAN_DIV, 1200, clock cycles each row is driven (≥2)
- DEBOUNCE, 4, consecutive identical frame comparisons required to accept a new matrix state (1..15)
- KEY_W, 4, key code width; 2^KEY_W ≥ ROWS*COLS

- hwclk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- row_n  output  ROWS  row drive, active-low one-hot
- col_n  input  COLS  column sense, active-low (externally pulled up); pre-synchronised by a 2-flop stage inside the block
- key_code  output  KEY_W  code of pressed key = row*COLS + col, stable while key_valid
- key_valid  output  1  press event pending
- key_ready  input  1  consumer accepts event when high with key_valid
- key_down  output  1  level: debounced matrix holds exactly one key
- key_multi  output  1  level: debounced matrix holds ≥2 keys
- overflow  output  1  sticky: press event dropped because previous event unaccepted

## Operation

- Scan: row index r cycles 0..ROWS-1, dwell counter d counts 0..SCAN_DIV-1 per row, wrapping r after ROWS-1 to 0. row_n = ~(1<<r).
- Sample: on cycle d==SCAN_DIV-1, synchronised ~col_n is written to raw frame bits [r*COLS +: COLS]. Sampling on the last dwell cycle is the settle margin.
- Frame end is the sample cycle of r==ROWS-1. At frame end, the completed raw frame is compared with the previous raw frame:
  - If equal, stable_cnt increments, saturating at DEBOUNCE.
  - Otherwise stable_cnt = 0.
  - Previous frame <= raw frame.
- Accept: when stable_cnt reaches DEBOUNCE and raw differs from the debounced matrix, the debounced matrix <= raw on the next cycle.
- Classify the debounced matrix by popcount: 0 = idle, 1 = single, ≥2 = multi. key_down = single; key_multi = multi. The encoder picks the sole set bit's index.
- Press event fires only on an idle→single transition of the debounced matrix.
  - single→multi→single produces no event; all keys must release (idle) first.
  - single→different single without idle (one debounced step) produces no event.
- Handshake, 1-deep output register:
  - An event loads key_code and sets key_valid.
  - key_valid clears on the cycle after key_valid & key_ready.
  - An event arriving while key_valid=1 and not accepted that cycle is dropped; it sets overflow, and key_code is unchanged.
  - An event arriving in the same cycle as acceptance loads normally; key_valid stays high.
- overflow clears only on rst.
- Reset values:
  - Outputs: row_n = ~1 (row 0 active), key_code=0, key_valid=0, key_down=0, key_multi=0, overflow=0.
  - Internal: r=0, d=0, stable_cnt=0, raw/previous/debounced frames all zero, synchroniser flops = inactive.
- rst mid-scan or mid-handshake abandons everything: any pending event is lost and the scan restarts at row 0.

## Timing

- Frame period F = ROWS*SCAN_DIV cycles.
- Debounced update: 1 cycle after the frame end at which stable_cnt hits DEBOUNCE. A press held from before frame k's first sample updates at the end of frame k+DEBOUNCE, +1 cycle.
- key_valid rises 1 cycle after the debounced update. key_down/key_multi update in the same cycle as key_valid.
- Column synchroniser adds 2 cycles; inputs must be stable ≥3 cycles before a sample cycle to be captured.
- key_valid holds indefinitely without key_ready; there is no timeout.

## Test plan

Bench parameters: ROWS=3, COLS=3, SCAN_DIV=4, DEBOUNCE=2, so F=12.

- Reset: assert rst 2 cycles → all outputs at reset values, row_n=3'b110; first row change to 3'b101 exactly 4 cycles after rst falls.
- Clean press: hold row1/col2 key (col_n[2] low while row_n[1] low) from reset, ready=1 → single key_valid pulse with key_code=5, key_down=1 within 3F+4 cycles; release → key_down=0, no further event.
- Bounce: toggle the key every 5 cycles for 40 cycles, then hold → no event during bouncing; exactly one event (code 5) after hold; stable_cnt reset observed.
- Ghost: press codes 0 and 4 together → key_multi=1, key_down=0, no event; release code 4 only → no event until full release and fresh press.
- Handshake/overflow: key_ready=0, press/release code 0, then press code 8 → key_valid stays with key_code=0, overflow=1; assert ready → key_valid drops next cycle, code 8 never presented.
- Reset mid-event: pending key_valid=1, pulse rst → key_valid=0, overflow=0, scan restarts at row 0.
